regfile_master: RTL

// - Initiator side of the register-file access interface (addr/rw/wdata/out).
// - Accepts one command via valid/ready, drives rf_addr/rf_rw/rf_wdata, samples rf_rdata, returns one response.
// - Sits between the SCI control path and the register file; it is the only agent driving register-file writes.

---
 rtl/regfile_master_pkg.sv | 26 ++
 rtl/regfile_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_master_pkg.sv
// Shared types for the register-file initiator.
// Op encodings, FSM states, default widths.
package regfile_master_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_ADD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RESP
  } state_e;

endpackage

// File: rtl/regfile_master.sv
// Register-file initiator: one cmd in, one rsp out.
// Ports: cmd_* (valid/ready), rsp_* (valid/ready), rf_* bus.
module regfile_master
  import regfile_master_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_ra_i,
  input  logic [ADDR_W-1:0] cmd_rb_i,
  input  logic [ADDR_W-1:0] cmd_rd_i,
  input  logic [DATA_W-1:0] cmd_imm_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_carry_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic              rf_rw_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [DATA_W-1:0] rf_rdata_i
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W:0]   sum;
  op_e               cop;
  logic              bad;

  function automatic logic oob(
    input logic [ADDR_W-1:0] a
  );
    return int'(a) >= NUM_REGS;
  endfunction

  // B is consumed straight off rf_rdata in RD_B.
  assign sum = {1'b0, a_q} + {1'b0, rf_rdata_i};
  assign cop = op_e'(cmd_op_i);

  always_comb begin
    bad = 1'b0;
    unique case (cop)
      OP_READ:  bad = oob(cmd_ra_i);
      OP_WRITE: bad = oob(cmd_rd_i);
      OP_MOVE:  bad = oob(cmd_ra_i)
                    | oob(cmd_rd_i);
      OP_ADD:   bad = oob(cmd_ra_i)
                    | oob(cmd_rb_i)
                    | oob(cmd_rd_i);
      default:  bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    a_d     = a_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rw_d    = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cop;
          rb_d    = cmd_rb_i;
          rd_d    = cmd_rd_i;
          res_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          if (bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (cop == OP_WRITE) begin
            addr_d  = cmd_rd_i;
            wdata_d = cmd_imm_i;
            res_d   = cmd_imm_i;
            state_d = S_WR_SETUP;
          end else begin
            addr_d  = cmd_ra_i;
            state_d = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        a_d = rf_rdata_i;
        unique case (op_q)
          OP_READ: begin
            res_d   = rf_rdata_i;
            state_d = S_RESP;
          end
          OP_MOVE: begin
            res_d   = rf_rdata_i;
            addr_d  = rd_q;
            wdata_d = rf_rdata_i;
            state_d = S_WR_SETUP;
          end
          default: begin
            addr_d  = rb_q;
            state_d = S_RD_B;
          end
        endcase
      end
      S_RD_B: begin
        res_d   = sum[DATA_W-1:0];
        carry_d = sum[DATA_W];
        addr_d  = rd_q;
        wdata_d = sum[DATA_W-1:0];
        state_d = S_WR_SETUP;
      end
      S_WR_SETUP: begin
        rw_d    = 1'b1;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      rb_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = res_q;
  assign rsp_carry_o = carry_q;
  assign rsp_err_o   = err_q;
  assign rf_addr_o   = addr_q;
  assign rf_rw_o     = rw_q;
  assign rf_wdata_o  = wdata_q;

endmodule
